// File: rtl/mem_access_capture_pkg.sv
// Shared types for the memory-stage capture block. The record layout gains a
// timestamp field when MEM_ACCESS_CAPTURE_TIMESTAMP_EN is defined.
package mem_access_capture_pkg;

  localparam int ADDR_W_D  = 16;
  localparam int DATA_W_D  = 16;
  localparam int STATE_W_D = 2;
  localparam int TS_W      = 16;

  typedef enum logic {IDLE, ARMED} fsm_state_e;

  typedef struct packed {
    logic [ADDR_W_D-1:0]  addr;
    logic [DATA_W_D-1:0]  din;
    logic [DATA_W_D-1:0]  memout;
    logic                 rd;
    logic [STATE_W_D-1:0] state;
`ifdef MEM_ACCESS_CAPTURE_TIMESTAMP_EN
    logic [TS_W-1:0]      ts;
`endif
  } rec_t;

endpackage

// File: rtl/mem_access_capture_fifo.sv
// Generic show-ahead FIFO; pointers carry an extra wrap bit to tell full from
// empty. The head word reads as zero while the FIFO is empty.
module mem_access_capture_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [W-1:0]               wdata,
  input  logic                       pop,
  output logic [W-1:0]               rdata,
  output logic                       valid,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr, rptr;
  logic         do_push, do_pop;

  assign valid   = (wptr != rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign level   = wptr - rptr;
  assign do_pop  = pop && valid;
  // A pop frees the head slot this edge, so a push into a full FIFO is still taken.
  assign do_push = push && (!full || do_pop);
  assign rdata   = valid ? mem[rptr[AW-1:0]] : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !reset) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/mem_access_capture.sv
// Captures a record of the memory-stage signals each time mem_state changes.
// Optional MEM_ACCESS_CAPTURE_TIMESTAMP_EN adds a cycle counter and rec_ts.
module mem_access_capture
  import mem_access_capture_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int STATE_W = 2,
  parameter int DEPTH   = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        DMem_addr,
  input  logic [DATA_W-1:0]        DMem_din,
  input  logic [DATA_W-1:0]        memout,
  input  logic                     DMem_rd,
  input  logic [STATE_W-1:0]       mem_state,
  output logic                     rec_valid,
  input  logic                     rec_ready,
  output logic [ADDR_W-1:0]        rec_addr,
  output logic [DATA_W-1:0]        rec_din,
  output logic [DATA_W-1:0]        rec_memout,
  output logic                     rec_rd,
  output logic [STATE_W-1:0]       rec_state,
`ifdef MEM_ACCESS_CAPTURE_TIMESTAMP_EN
  output logic [TS_W-1:0]          rec_ts,
`endif
  output logic                     overflow,
  output logic [7:0]               drop_cnt,
  output logic [$clog2(DEPTH):0]   level
);
`ifdef MEM_ACCESS_CAPTURE_TIMESTAMP_EN
  localparam int REC_W = ADDR_W + 2*DATA_W + 1 + STATE_W + TS_W;
`else
  localparam int REC_W = ADDR_W + 2*DATA_W + 1 + STATE_W;
`endif

  fsm_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   snap_addr;
  logic [DATA_W-1:0]   snap_din, snap_memout;
  logic                snap_rd;
  logic [STATE_W-1:0]  snap_state;
  logic                push, full, drop;
  logic [REC_W-1:0]    wdata, rdata;

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // IDLE only primes the snapshot, so nothing is pushed the cycle after reset.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      IDLE:    state_d = ARMED;
      ARMED:   push    = (mem_state != snap_state);
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      snap_addr   <= '0;
      snap_din    <= '0;
      snap_memout <= '0;
      snap_rd     <= 1'b0;
      snap_state  <= '0;
    end else begin
      snap_addr   <= DMem_addr;
      snap_din    <= DMem_din;
      snap_memout <= memout;
      snap_rd     <= DMem_rd;
      snap_state  <= mem_state;
    end
  end

`ifdef MEM_ACCESS_CAPTURE_TIMESTAMP_EN
  logic [TS_W-1:0] cyc_cnt, snap_ts;

  always_ff @(posedge clock) begin
    if (reset) begin
      cyc_cnt <= '0;
      snap_ts <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 1'b1;
      snap_ts <= cyc_cnt;
    end
  end

  assign wdata = {snap_addr, snap_din, snap_memout, snap_rd, snap_state, snap_ts};
  assign {rec_addr, rec_din, rec_memout, rec_rd, rec_state, rec_ts} = rdata;
`else
  assign wdata = {snap_addr, snap_din, snap_memout, snap_rd, snap_state};
  assign {rec_addr, rec_din, rec_memout, rec_rd, rec_state} = rdata;
`endif

  assign drop = push && full && !(rec_valid && rec_ready);

  always_ff @(posedge clock) begin
    if (reset) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  mem_access_capture_fifo #(.W(REC_W), .DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .wdata (wdata),
    .pop   (rec_ready),
    .rdata (rdata),
    .valid (rec_valid),
    .full  (full),
    .level (level)
  );

endmodule

// File: tb/tb_mem_access_capture.sv
// Randomized and directed bench for mem_access_capture against a queue-based
// reference model of the capture rules.
module tb_mem_access_capture;
  import mem_access_capture_pkg::*;

  localparam int DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] DMem_addr = '0, DMem_din = '0, memout = '0;
  logic        DMem_rd = 1'b0;
  logic [1:0]  mem_state = '0;
  logic        rec_ready = 1'b0;
  logic        rec_valid, rec_rd, overflow;
  logic [15:0] rec_addr, rec_din, rec_memout;
  logic [1:0]  rec_state;
  logic [7:0]  drop_cnt;
  logic [3:0]  level;
`ifdef MEM_ACCESS_CAPTURE_TIMESTAMP_EN
  logic [15:0] rec_ts;
`endif

  mem_access_capture #(.ADDR_W(16), .DATA_W(16), .STATE_W(2), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .DMem_addr(DMem_addr), .DMem_din(DMem_din), .memout(memout),
    .DMem_rd(DMem_rd), .mem_state(mem_state),
    .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_addr(rec_addr), .rec_din(rec_din), .rec_memout(rec_memout),
    .rec_rd(rec_rd), .rec_state(rec_state),
`ifdef MEM_ACCESS_CAPTURE_TIMESTAMP_EN
    .rec_ts(rec_ts),
`endif
    .overflow(overflow), .drop_cnt(drop_cnt), .level(level)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;

  // reference model state
  rec_t        q[$];
  rec_t        m_snap;
  bit          m_armed;
  bit          m_ovf;
  int          m_drops;
  logic [15:0] m_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit push, popped;
    if (reset) begin
      q.delete();
      m_snap  = '0;
      m_armed = 1'b0;
      m_ovf   = 1'b0;
      m_drops = 0;
      m_cyc   = '0;
    end else begin
      push   = m_armed && (mem_state != m_snap.state);
      popped = (q.size() > 0) && rec_ready;
      if (popped) void'(q.pop_front());
      if (push) begin
        if (q.size() < DEPTH) q.push_back(m_snap);
        else begin
          m_ovf = 1'b1;
          if (m_drops < 255) m_drops++;
        end
      end
      m_snap.addr   = DMem_addr;
      m_snap.din    = DMem_din;
      m_snap.memout = memout;
      m_snap.rd     = DMem_rd;
      m_snap.state  = mem_state;
`ifdef MEM_ACCESS_CAPTURE_TIMESTAMP_EN
      m_snap.ts     = m_cyc;
`endif
      m_cyc   = m_cyc + 16'd1;
      m_armed = 1'b1;
    end
  endtask

  task automatic compare_all();
    rec_t h;
    h = (q.size() > 0) ? q[0] : '0;
    chk("valid",    {31'd0, rec_valid}, {31'd0, q.size() > 0});
    chk("level",    {28'd0, level}, q.size());
    chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    chk("drop_cnt", {24'd0, drop_cnt}, m_drops);
    chk("addr",     {16'd0, rec_addr}, {16'd0, h.addr});
    chk("din",      {16'd0, rec_din}, {16'd0, h.din});
    chk("memout",   {16'd0, rec_memout}, {16'd0, h.memout});
    chk("rd",       {31'd0, rec_rd}, {31'd0, h.rd});
    chk("state",    {30'd0, rec_state}, {30'd0, h.state});
`ifdef MEM_ACCESS_CAPTURE_TIMESTAMP_EN
    chk("ts",       {16'd0, rec_ts}, {16'd0, h.ts});
`endif
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    // reset state, then a quiet bus produces nothing
    do_reset();
    chk("rst_level", {28'd0, level}, 32'd0);
    chk("rst_valid", {31'd0, rec_valid}, 32'd0);
    for (int i = 0; i < 10; i++) step();
    chk("quiet_level", {28'd0, level}, 32'd0);
    chk("quiet_valid", {31'd0, rec_valid}, 32'd0);

    // single record: snapshot taken in the IDLE cycle, pushed on the change
    DMem_addr = 16'h3000; DMem_din = 16'h1234; memout = 16'hBEEF;
    DMem_rd = 1'b1; mem_state = 2'd1;
    do_reset();
    step();
    chk("one_valid_early", {31'd0, rec_valid}, 32'd0);
    mem_state = 2'd2; DMem_addr = 16'h3004;
    step();
    chk("one_valid", {31'd0, rec_valid}, 32'd1);
    chk("one_addr",  {16'd0, rec_addr}, 32'h3000);
    chk("one_din",   {16'd0, rec_din}, 32'h1234);
    chk("one_mem",   {16'd0, rec_memout}, 32'hBEEF);
    chk("one_rd",    {31'd0, rec_rd}, 32'd1);
    chk("one_state", {30'd0, rec_state}, 32'd1);
    step();
    chk("one_level", {28'd0, level}, 32'd1);

    // nine changes with no consumer: one dropped, head intact
    mem_state = 2'd0; DMem_addr = 16'h1000;
    do_reset();
    step();
    for (int k = 1; k <= 9; k++) begin
      mem_state = 2'(k % 4);
      DMem_addr = 16'h1000 + 16'(k);
      step();
    end
    chk("ovf_level", {28'd0, level}, 32'd8);
    chk("ovf_flag",  {31'd0, overflow}, 32'd1);
    chk("ovf_drops", {24'd0, drop_cnt}, 32'd1);
    chk("ovf_head",  {16'd0, rec_addr}, 32'h1000);

    // full with simultaneous push and pop
    rec_ready = 1'b1; mem_state = 2'd2; DMem_addr = 16'h100A;
    step();
    chk("fullpp_level", {28'd0, level}, 32'd8);
    chk("fullpp_drops", {24'd0, drop_cnt}, 32'd1);
    chk("fullpp_head",  {16'd0, rec_addr}, 32'h1001);
    rec_ready = 1'b0;

    // mid-operation reset discards records; first post-reset change is ignored
    for (int k = 0; k < 3; k++) begin
      mem_state = mem_state + 2'd1;
      step();
    end
    do_reset();
    chk("rr_level", {28'd0, level}, 32'd0);
    chk("rr_ovf",   {31'd0, overflow}, 32'd0);
    mem_state = 2'd3;
    step();
    chk("rr_nopush", {28'd0, level}, 32'd0);

`ifdef MEM_ACCESS_CAPTURE_TIMESTAMP_EN
    // cycle c after reset is sampled by edge c+1
    mem_state = 2'd0; rec_ready = 1'b0;
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      mem_state = (c >= 9) ? 2'd2 : (c >= 5) ? 2'd1 : 2'd0;
      step();
    end
    chk("ts_first", {16'd0, rec_ts}, 32'd4);
    rec_ready = 1'b1;
    step();
    chk("ts_second", {16'd0, rec_ts}, 32'd8);
    rec_ready = 1'b0;
`endif

    // randomized traffic with bursts of back-pressure
    for (int i = 0; i < 1500; i++) begin
      DMem_addr = 16'($urandom);
      DMem_din  = 16'($urandom);
      memout    = 16'($urandom);
      DMem_rd   = 1'($urandom);
      if ($urandom_range(0, 9) < 4) mem_state = 2'($urandom);
      rec_ready = ((i / 100) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
      reset     = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
